mmio_port_responder: RTL
========================

Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data bus: answers load/store requests from the MIPS core with a valid/ready handshake and configurable wait states.
- Owns the 8-bit output port register (drives PortOut).
- Synchronises the external PortIn pins and latches sticky edge flags, with a maskable interrupt line.
- Sits beside DataMemory; the core's address decode routes the I/O window here.

Parameters:
- PORT_WIDTH, 8, width of port_in / port_out.
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).
- BASE_ADDR, 32'h1000_0000, byte base of the 16-byte register window; bits [3:0] must be zero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder accepts request this cycle.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  unmapped or misaligned access, qualified by rsp_valid.
- port_in  input  PORT_WIDTH  asynchronous external pins.
- port_out  output  PORT_WIDTH  output port register.
- irq  output  1  OR of (edge_flags & irq_mask).

Behaviour:
- Reset (reset low, asynchronous):
  - All registers, flags and synchroniser flops clear to 0; FSM goes to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, port_out=0, irq=0.
  - Reset asserted mid-transaction drops the transaction: no response, and no write if not yet accepted.
- Register map (offset from BASE_ADDR):
  - 0x0 PORT_OUT: RW, bits [PORT_WIDTH-1:0]; upper bits read 0.
  - 0x4 PORT_IN: RO, synchronised pin value; writes ignored, no error.
  - 0x8 EDGE_FLAGS: sticky flags; write-1-to-clear.
  - 0xC IRQ_MASK: RW, PORT_WIDTH bits.
- Decode and errors:
  - Hit when req_addr[31:4] == BASE_ADDR[31:4].
  - Miss, or req_addr[1:0] != 0, gives rsp_err=1 and rsp_rdata=0; no register changes.
- FSM states IDLE, WAIT, RESP:
  - req_ready = (state == IDLE), combinational from state only.
  - Accept = req_valid & req_ready at a rising edge. Store data is written at the accept edge.
  - Accept edge: go to WAIT with counter = WAIT_CYCLES-1; go directly to RESP if WAIT_CYCLES == 0.
  - WAIT: count down; at 0 go to RESP.
  - Load data and rsp_err are captured on the edge entering RESP, so a load reflects any edge flag set during WAIT.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Latency: rsp_valid is high in cycle A+WAIT_CYCLES+1, where A is the accept cycle. Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
- Request inputs are sampled only at accept; they are don't-care in WAIT/RESP.
- Input path:
  - port_in passes through 2 flops to give sync; a third flop holds prev.
  - rise = sync & ~prev sets the corresponding EDGE_FLAGS bit.
  - Edge-to-flag latency is 3 edges from the pin change.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins, flag stays 1.
- irq is registered: it updates one cycle after a flag or mask change.
- Flags saturate at 1; no counting or overflow.

Optional Feature:
- MMIO_FALLING_EDGE_EN defined:
  - fall = ~sync & prev also sets EDGE_FLAGS.
  - Adds 0x8 read bits [2*PORT_WIDTH-1:PORT_WIDTH] = falling flags; rising flags stay in the low bits.
  - W1C applies to both halves.
  - irq = |((rise_flags | fall_flags) & irq_mask).
- Undefined: only rising edges are detected; EDGE_FLAGS upper bits read 0.

Test Plan:
- Reset, then store 32'h0000_00A5 to 0x1000_0000 with WAIT_CYCLES=1 -> port_out=8'hA5 after the accept edge; rsp_valid in cycle A+2 with rsp_err=0; load of 0x1000_0000 returns 32'h0000_00A5.
- port_in stepped 8'h00 -> 8'h81, then load 0x1000_0004 and 0x1000_0008 -> 32'h81 and 32'h81. Store 32'h01 to 0x8 -> load returns 32'h80.
- IRQ_MASK=8'h80, pin 7 rises -> irq=1 one cycle after the flag sets. Store 32'h80 to 0x8 in the same cycle as a new rising edge on pin 7 -> flag stays 1, irq stays 1.
- Load 0x2000_0000 and load 0x1000_0002 -> rsp_err=1, rsp_rdata=0, port_out unchanged. WAIT_CYCLES=0 -> rsp_valid in cycle A+1.
- Assert reset while FSM is in WAIT -> no rsp_valid; req_ready=1, port_out=0, flags=0 immediately.
- Build with MMIO_FALLING_EDGE_EN, port_in 8'h01 -> 8'h00 -> EDGE_FLAGS reads 32'h0000_0101 (rising bit 0 from the earlier rise, falling bit 8). Build without it -> same sequence reads 32'h0000_0001.

Source files
------------

// File: rtl/mmio_port_responder_if.sv
// Load/store request and response signals between the core and the MMIO port responder.
interface mmio_port_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO responder owning the output port, synchronised input pins, sticky edge flags and irq.
// Define MMIO_FALLING_EDGE_EN to also flag falling edges in EDGE_FLAGS[2*PORT_WIDTH-1:PORT_WIDTH].
module mmio_port_responder #(
    parameter int unsigned PORT_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    mmio_port_responder_if.slave  bus,
    input  logic [PORT_WIDTH-1:0] port_in,
    output logic [PORT_WIDTH-1:0] port_out,
    output logic                  irq
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            off_q;
    logic                  write_q, err_q;
    logic [31:0]           rdata_q;
    logic                  rsp_err_q;
    logic [PORT_WIDTH-1:0] port_out_q, mask_q;
    logic [PORT_WIDTH-1:0] sync1_q, sync_q, prev_q;
    logic [PORT_WIDTH-1:0] rise_q, rise_d, rise;
    logic [PORT_WIDTH-1:0] fall_q, fall_d, fall;
    logic                  irq_q;

    logic                  accept, req_err, wr_ok, w1c, resp_enter;
    logic [1:0]            cur_off;
    logic                  cur_write, cur_err;
    logic [31:0]           rd;

    assign accept  = bus.req_valid & (state_q == StIdle);
    assign req_err = (bus.req_addr[31:4] != BASE_ADDR[31:4]) | (bus.req_addr[1:0] != 2'b00);
    assign wr_ok   = accept & bus.req_write & ~req_err;
    assign w1c     = wr_ok & (bus.req_addr[3:2] == 2'd2);

    // With zero wait states RESP is entered on the accept edge, so decode straight from the bus.
    assign cur_off    = (state_q == StIdle) ? bus.req_addr[3:2] : off_q;
    assign cur_write  = (state_q == StIdle) ? bus.req_write : write_q;
    assign cur_err    = (state_q == StIdle) ? req_err : err_q;
    assign resp_enter = (state_d == StResp) & (state_q != StResp);

    assign rise = sync_q & ~prev_q;

`ifdef MMIO_FALLING_EDGE_EN
    logic unused_wdata;
    assign unused_wdata = ^bus.req_wdata[31:2*PORT_WIDTH];
    assign fall   = ~sync_q & prev_q;
    assign fall_d = (fall_q & ~(w1c ? bus.req_wdata[2*PORT_WIDTH-1:PORT_WIDTH] : '0)) | fall;
`else
    logic unused_wdata;
    assign unused_wdata = ^bus.req_wdata[31:PORT_WIDTH];
    assign fall   = '0;
    assign fall_d = '0;
`endif

    // Set wins over a same-cycle write-1-to-clear.
    assign rise_d = (rise_q & ~(w1c ? bus.req_wdata[PORT_WIDTH-1:0] : '0)) | rise;

    always_comb begin
        rd = '0;
        case (cur_off)
            2'd0: rd[PORT_WIDTH-1:0] = port_out_q;
            2'd1: rd[PORT_WIDTH-1:0] = sync_q;
            2'd2: begin
                rd[PORT_WIDTH-1:0] = rise_q;
`ifdef MMIO_FALLING_EDGE_EN
                rd[2*PORT_WIDTH-1:PORT_WIDTH] = fall_q;
`endif
            end
            default: rd[PORT_WIDTH-1:0] = mask_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            off_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rsp_err_q  <= 1'b0;
            port_out_q <= '0;
            mask_q     <= '0;
            sync1_q    <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= port_in;
            sync_q  <= sync1_q;
            prev_q  <= sync_q;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= |((rise_q | fall_q) & mask_q);
            if (accept) begin
                off_q   <= bus.req_addr[3:2];
                write_q <= bus.req_write;
                err_q   <= req_err;
            end
            if (wr_ok && bus.req_addr[3:2] == 2'd0) port_out_q <= bus.req_wdata[PORT_WIDTH-1:0];
            if (wr_ok && bus.req_addr[3:2] == 2'd3) mask_q     <= bus.req_wdata[PORT_WIDTH-1:0];
            if (resp_enter) begin
                rdata_q   <= (cur_write | cur_err) ? 32'd0 : rd;
                rsp_err_q <= cur_err;
            end else if (state_q == StResp) begin
                rdata_q   <= '0;
                rsp_err_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign port_out      = port_out_q;
    assign irq           = irq_q;

endmodule
